// File: rtl/rr_grant_ctrl_pkg.sv
// arb_pkg: shared types and constants for the 4-way round-robin grant controller
package arb_pkg;
    typedef enum logic {IDLE, GRANT} state_t;
    localparam int NREQ = 4;
    localparam int IDX_W = 2;
    localparam logic [NREQ-1:0] GRANT_NONE = 4'b1111;
endpackage

// File: rtl/rr_grant_ctrl_if.sv
// rr_grant_ctrl_if: request/grant bundle between requesters (master) and arbiter (slave)
interface rr_grant_ctrl_if import arb_pkg::*; #(parameter int CNT_W = 8);
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  grant_n;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic [CNT_W-1:0] hold_cnt;
    modport master (output req, input grant_n, gnt_idx, gnt_valid, hold_cnt);
    modport slave (input req, output grant_n, gnt_idx, gnt_valid, hold_cnt);
endinterface

// File: rtl/rr_grant_ctrl_dec.sv
// onehot_low_dec: 2-to-4 active-low decode with enable, all-high when disabled
module onehot_low_dec import arb_pkg::*; (
    input  logic [IDX_W-1:0] idx_i,
    input  logic             en_i,
    output logic [NREQ-1:0]  dec_n_o
);
    assign dec_n_o = en_i ? ~(NREQ'(1) << idx_i) : GRANT_NONE;
endmodule

// File: rtl/rr_grant_ctrl.sv
// rr_grant_ctrl: round-robin arbiter sharing one resource among 4 requesters with hold timeout
module rr_grant_ctrl import arb_pkg::*; #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W = 8
) (
    input logic           clk,
    input logic           rst,
    rr_grant_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_MAX == 0 ? 0 : HOLD_MAX - 1);
    state_t state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d, idx_q, idx_d;
    logic valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NREQ-1:0] grant_n_q, grant_n_d;
    logic [IDX_W:0] pick;
    logic keep;
    // {found, index} of the first request after p, wrapping so p itself is scanned last
    function automatic logic [IDX_W:0] rr_pick(input logic [NREQ-1:0] r, input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] c;
        rr_pick = '0;
        for (int i = NREQ; i >= 1; i--) begin
            c = p + IDX_W'(i);
            if (r[c]) rr_pick = {1'b1, c};
        end
    endfunction
    always_comb begin
        keep = state_q == GRANT && bus.req[idx_q] && !(HOLD_MAX != 0 && cnt_q == LAST);
        pick = rr_pick(bus.req, state_q == GRANT ? idx_q : ptr_q);
        state_d = state_q;
        ptr_d = ptr_q;
        idx_d = idx_q;
        cnt_d = '0;
        if (keep) cnt_d = cnt_q == '1 ? cnt_q : cnt_q + 1'b1;
        else begin
            ptr_d = state_q == GRANT ? idx_q : ptr_q;
            state_d = pick[IDX_W] ? GRANT : IDLE;
            idx_d = pick[IDX_W] ? pick[IDX_W-1:0] : idx_q;
        end
        valid_d = state_d == GRANT;
    end
    onehot_low_dec u_dec (.idx_i(idx_d), .en_i(valid_d), .dec_n_o(grant_n_d));
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q <= 2'b11;
            idx_q <= '0;
            valid_q <= 1'b0;
            cnt_q <= '0;
            grant_n_q <= GRANT_NONE;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            idx_q <= idx_d;
            valid_q <= valid_d;
            cnt_q <= cnt_d;
            grant_n_q <= grant_n_d;
        end
    end
    assign bus.grant_n = grant_n_q;
    assign bus.gnt_idx = idx_q;
    assign bus.gnt_valid = valid_q;
    assign bus.hold_cnt = cnt_q;
endmodule

// File: tb/tb_rr_grant_ctrl.sv
// tb_rr_grant_ctrl: scoreboard bench driving two arbiters (HOLD_MAX=1 and HOLD_MAX=8)
module tb_rr_grant_ctrl;
    import arb_pkg::*;
    typedef struct packed {
        logic [3:0] gn;
        logic [1:0] idx;
        logic       v;
        logic [7:0] cnt;
        logic       chk_idx;
    } exp_t;
    localparam exp_t IDL = '{4'b1111, 2'd0, 1'b0, 8'd0, 1'b0};
    localparam exp_t RST = '{4'b1111, 2'd0, 1'b0, 8'd0, 1'b1};
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    rr_grant_ctrl_if #(.CNT_W(8)) ifa ();
    rr_grant_ctrl_if #(.CNT_W(8)) ifb ();
    rr_grant_ctrl #(.HOLD_MAX(1), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    rr_grant_ctrl #(.HOLD_MAX(8), .CNT_W(8)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
    exp_t qa[$];
    exp_t qb[$];
    int checks = 0;
    int errors = 0;
    function automatic exp_t g(input logic [3:0] gn, input logic [1:0] idx, input logic [7:0] cnt);
        return '{gn, idx, 1'b1, cnt, 1'b1};
    endfunction
    task automatic cyc(input logic r, input logic [3:0] ra, input logic [3:0] rb, input exp_t ea, input exp_t eb);
        @(negedge clk);
        rst = r;
        ifa.req = ra;
        ifb.req = rb;
        qa.push_back(ea);
        qb.push_back(eb);
    endtask
    task automatic chk(input string nm, input exp_t e, input logic [3:0] gn, input logic [1:0] idx,
                       input logic v, input logic [7:0] cnt);
        checks++;
        if (gn !== e.gn || v !== e.v || cnt !== e.cnt || (e.chk_idx && idx !== e.idx)) begin
            errors++;
            $display("FAIL %s t=%0t: got grant_n=%b idx=%0d valid=%b cnt=%0d, want grant_n=%b idx=%0d valid=%b cnt=%0d",
                     nm, $time, gn, idx, v, cnt, e.gn, e.idx, e.v, e.cnt);
        end
    endtask
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) chk("dut_a", qa.pop_front(), ifa.grant_n, ifa.gnt_idx, ifa.gnt_valid, ifa.hold_cnt);
            if (qb.size() > 0) chk("dut_b", qb.pop_front(), ifb.grant_n, ifb.gnt_idx, ifb.gnt_valid, ifb.hold_cnt);
        end
    end
    initial begin
        ifa.req = '0;
        ifb.req = '0;
        repeat (2) cyc(1, 4'b0000, 4'b0000, RST, RST);
        cyc(0, 4'b1111, 4'b0000, g(4'b1110, 0, 0), IDL);
        cyc(0, 4'b1111, 4'b0000, g(4'b1101, 1, 0), IDL);
        cyc(0, 4'b1111, 4'b0000, g(4'b1011, 2, 0), IDL);
        cyc(0, 4'b1111, 4'b0000, g(4'b0111, 3, 0), IDL);
        cyc(0, 4'b1111, 4'b0000, g(4'b1110, 0, 0), IDL);
        cyc(0, 4'b0000, 4'b0000, IDL, IDL);
        cyc(0, 4'b0100, 4'b0000, g(4'b1011, 2, 0), IDL);
        repeat (2) cyc(0, 4'b0000, 4'b0000, IDL, IDL);
        for (int k = 0; k < 8; k++)
            cyc(0, 4'b0000, k == 3 ? 4'b1011 : 4'b0011, IDL, g(4'b1110, 0, 8'(k)));
        cyc(0, 4'b0000, 4'b0011, IDL, g(4'b1101, 1, 0));
        cyc(0, 4'b0000, 4'b0011, IDL, g(4'b1101, 1, 1));
        cyc(0, 4'b0000, 4'b0000, IDL, IDL);
        for (int k = 0; k < 20; k++)
            cyc(0, 4'b0000, 4'b0100, IDL, g(4'b1011, 2, 8'(k % 8)));
        cyc(0, 4'b0000, 4'b0000, IDL, IDL);
        cyc(0, 4'b0000, 4'b1001, IDL, g(4'b0111, 3, 0));
        cyc(1, 4'b0000, 4'b1001, RST, RST);
        cyc(0, 4'b0000, 4'b1001, IDL, g(4'b1110, 0, 0));
        cyc(0, 4'b0000, 4'b1000, IDL, g(4'b0111, 3, 0));
        cyc(0, 4'b0000, 4'b0000, IDL, IDL);
        repeat (3) @(negedge clk);
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending expectations, want 0/0", qa.size(), qb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
